// File: rtl/fetch_stage.sv
// Fetch stage: program counter, in-order instruction reads, prefetch queue and redirect handling.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        is_pc_changing,
  input  logic        has_flushed,
  input  logic [31:0] next_pc,
  input  logic        hold,
  output logic        is_valid,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic        mem_wait,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_data
);
  localparam int          AW    = $clog2(DEPTH);
  localparam int          CW    = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP   = 32'h80000000;

  typedef enum logic [1:0] {RUN, STALL, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   af_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, af_rd, af_wr;
  logic [CW-1:0] count, outst, count_nxt, outst_nxt;
  logic [CW:0]   credit;
  logic          accept, head_vld, bypass, pop, push;

  assign accept   = mem_read && !mem_wait;
  assign head_vld = (count != '0) && (state != DRAIN);
`ifdef FETCH_BYPASS_EN
  assign bypass   = mem_data_valid && (count == '0) && !hold && (state != DRAIN) && !has_flushed;
`else
  assign bypass   = 1'b0;
`endif
  assign pop      = head_vld && !hold && !has_flushed;
  // A bypassed word is always taken by decode, so it never occupies a slot.
  assign push     = mem_data_valid && (state != DRAIN) && !has_flushed && !bypass;

  assign count_nxt = has_flushed ? '0 : count + CW'(push) - CW'(pop);
  assign outst_nxt = outst + CW'(accept) - CW'(mem_data_valid);
  assign credit    = {1'b0, count_nxt} + {1'b0, outst_nxt};
  assign mem_address = fetch_pc;

  always_comb begin
    is_valid    = head_vld;
    pc          = head_vld ? q_addr[rd_ptr] : '0;
    instruction = head_vld ? q_data[rd_ptr] : NOP;
    if (bypass) begin
      is_valid    = 1'b1;
      pc          = af_mem[af_rd];
      instruction = mem_data;
    end
  end

  always_comb begin
    state_nxt = state;
    if (has_flushed) state_nxt = (outst_nxt != '0) ? DRAIN : RUN;
    else begin
      case (state)
        RUN:     if (is_pc_changing) state_nxt = STALL;
        STALL:   if (!is_pc_changing) state_nxt = RUN;
        DRAIN:   if (outst_nxt == '0) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      count    <= '0;
      outst    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      af_rd    <= '0;
      af_wr    <= '0;
      mem_read <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      outst <= outst_nxt;
      // Sum only shrinks while a request waits, so a pending request stays up until taken.
      mem_read <= (state_nxt == RUN) && (credit < LIMIT);
      if (has_flushed) fetch_pc <= next_pc;
      else if (accept) fetch_pc <= fetch_pc + PC_STEP;
      if (has_flushed) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
      end
      if (accept)         af_wr <= af_wr + AW'(1);
      if (mem_data_valid) af_rd <= af_rd + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_addr[wr_ptr] <= af_mem[af_rd];
      q_data[wr_ptr] <= mem_data;
    end
    if (accept) af_mem[af_wr] <= fetch_pc;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: startup vector table, directed corner sequences, randomized run
// against an in-order pc/address scoreboard and a latency-modelled instruction memory.
module tb_fetch_stage;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h80000000;
`ifdef FETCH_BYPASS_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif

  logic        clock = 1'b0, reset_n = 1'b1;
  logic        is_pc_changing = 1'b0, has_flushed = 1'b0, hold = 1'b0;
  logic [31:0] next_pc = '0;
  logic        is_valid, mem_read;
  logic [31:0] pc, instruction, mem_address;
  logic        mem_wait = 1'b0, mem_data_valid = 1'b0;
  logic [31:0] mem_data = '0;

  always #5 clock = ~clock;

  fetch_stage #(.DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clock(clock), .reset_n(reset_n), .is_pc_changing(is_pc_changing),
    .has_flushed(has_flushed), .next_pc(next_pc), .hold(hold),
    .is_valid(is_valid), .pc(pc), .instruction(instruction),
    .mem_read(mem_read), .mem_address(mem_address), .mem_wait(mem_wait),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic w; logic rd; logic [31:0] addr; logic vld; logic [31:0] pc; } vec_t;

  mreq_t       memq[$];
  logic [31:0] acc_log[$];
  int          total = 0, bad = 0, cyc_n = 0, lat = 1, last_due = 0;
  int          held = 0, disc = 0, n_xfer = 0;
  logic [31:0] exp_pc = 32'h0, exp_req = 32'h0;
  logic        h_v = 0, c_v = 0, f_v = 0, w_v = 0;
  logic [31:0] n_v = '0;
  logic        s_vld, s_rd, o_xfer, o_acc;
  logic [31:0] s_pc, s_ins, s_addr, o_pc;
  logic        p_hold_vld = 0, p_wait_req = 0;
  logic [31:0] p_pc, p_ins, p_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // One cycle: drive inputs and memory at negedge, sample and score, return before posedge.
  task automatic cyc();
    logic r;
    logic [31:0] raddr;
    mreq_t m;
    @(negedge clock);
    hold = h_v; is_pc_changing = c_v; has_flushed = f_v; next_pc = n_v; mem_wait = w_v;
    r = (memq.size() > 0) && (memq[0].due <= cyc_n);
    raddr = r ? memq[0].addr : 32'h0;
    mem_data_valid = r;
    mem_data = r ? mem_word(raddr) : $urandom;
    #1;
    s_vld = is_valid; s_pc = pc; s_ins = instruction; s_rd = mem_read; s_addr = mem_address;
    if (p_hold_vld) begin
      chkb("hold_vld", s_vld, 1'b1); chk("hold_pc", s_pc, p_pc); chk("hold_ins", s_ins, p_ins);
    end
    if (p_wait_req) begin
      chkb("wait_rd", s_rd, 1'b1); chk("wait_addr", s_addr, p_addr);
    end
    if (!s_vld) chk("nop", s_ins, NOP);
    o_xfer = s_vld && !hold && !has_flushed;
    o_acc  = s_rd && !mem_wait;
    o_pc   = s_pc;
    if (o_xfer) begin
      chk("pc", s_pc, exp_pc); chk("ins", s_ins, mem_word(exp_pc));
      exp_pc += 4; held--; n_xfer++;
    end
    if (r) void'(memq.pop_front());
    if (o_acc) begin
      chk("req_addr", s_addr, exp_req);
      exp_req += 4;
      m.addr = s_addr;
      m.due = (cyc_n + lat > last_due) ? cyc_n + lat : last_due;
      last_due = m.due;
      memq.push_back(m);
      acc_log.push_back(s_addr);
    end
    if (has_flushed) begin
      disc = memq.size(); held = 0; exp_pc = next_pc; exp_req = next_pc;
    end else if (r) begin
      if (disc > 0) disc--; else held++;
    end
    chkb("credit", (held + memq.size()) <= DEPTH, 1'b1);
    p_hold_vld = s_vld && hold && !has_flushed;
    p_pc = s_pc; p_ins = s_ins;
    p_wait_req = s_rd && mem_wait && !is_pc_changing && !has_flushed;
    p_addr = s_addr;
    cyc_n++;
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    hold = 0; is_pc_changing = 0; has_flushed = 0; mem_wait = 0; mem_data_valid = 0;
    reset_n = 1'b0;
    #1;
    chkb("rst_vld", is_valid, 1'b0); chk("rst_ins", instruction, NOP);
    chkb("rst_rd", mem_read, 1'b0); chk("rst_pc", pc, 32'h0); chk("rst_addr", mem_address, 32'h0);
    memq.delete(); acc_log.delete();
    held = 0; disc = 0; exp_pc = 0; exp_req = 0; last_due = 0;
    p_hold_vld = 0; p_wait_req = 0;
    h_v = 0; c_v = 0; f_v = 0; w_v = 0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int   n0;
    logic got;
    tbl[0] = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[1] = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[3] = '{1'b1, 1'b1, 32'd4,  1'b1, 32'd0};
    tbl[4] = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[5] = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[6] = '{1'b0, 1'b1, 32'd8,  1'b0, 32'd0};
    tbl[7] = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd4};
    tbl[8] = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd8};
    tbl[9] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd12};

    // Startup with latency 1 and a 3-cycle mem_wait on address 4
    do_reset();
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      w_v = tbl[k].w;
      cyc();
      chkb("t_rd", s_rd, tbl[k].rd);
      chk("t_addr", s_addr, tbl[k].addr);
      if (k + BL < 10) begin
        chkb("t_vld", s_vld, tbl[k+BL].vld);
        if (tbl[k+BL].vld) chk("t_pc", s_pc, tbl[k+BL].pc);
      end
    end
    w_v = 0;

    // Decode holds for 5 cycles: credit fills, requests stop
    h_v = 1;
    repeat (5) cyc();
    chkb("hold_rd_off", s_rd, 1'b0);
    chk("hold_fill", 32'(held + memq.size()), 32'(DEPTH));
    h_v = 0;
    repeat (12) cyc();

    // pc-changing at pc 8, redirect to 0x100 with reads in flight
    do_reset();
    lat = 3;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (o_xfer && o_pc == 32'd8) begin got = 1; break; end
    end
    chkb("see_pc8", got, 1'b1);
    c_v = 1; cyc();
    f_v = 1; n_v = 32'h100; cyc();
    chkb("drain_out", disc >= 2, 1'b1);
    f_v = 0; c_v = 0;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      n0 = disc;
      cyc();
      if (i == 0) chkb("flush_vld", s_vld, 1'b0);
      if (n0 > 0) chkb("drain_rd", s_rd, 1'b0);
      if (o_xfer) begin chk("redir_pc", o_pc, 32'h100); got = 1; break; end
    end
    chkb("redir_seen", got, 1'b1);

    // Sequential fetch across the 32-bit wrap
    f_v = 1; n_v = 32'hFFFFFFFC; cyc();
    f_v = 0;
    acc_log.delete();
    for (int i = 0; i < 30 && acc_log.size() < 2; i++) cyc();
    chk("wrap_cnt", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() >= 2) begin
      chk("wrap_a0", acc_log[0], 32'hFFFFFFFC);
      chk("wrap_a1", acc_log[1], 32'h0);
    end
    repeat (6) cyc();

    // Fill the queue under hold, then reset mid-stream
    h_v = 1;
    for (int i = 0; i < 30 && held < DEPTH; i++) cyc();
    chk("full_held", 32'(held), 32'(DEPTH));
    chkb("full_vld", s_vld, 1'b1);
    do_reset();
    lat = 2;
    for (int i = 0; i < 10 && acc_log.size() < 1; i++) cyc();
    chk("restart_cnt", 32'(acc_log.size()), 32'd1);
    if (acc_log.size() >= 1) chk("restart_addr", acc_log[0], 32'h0);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 3);
      h_v = ($urandom_range(0, 9) < 3);
      w_v = ($urandom_range(0, 3) == 0);
      f_v = 0;
      if (c_v) begin
        if ($urandom_range(0, 3) == 0) begin
          c_v = 0;
          if ($urandom_range(0, 1) == 1) begin f_v = 1; n_v = $urandom & 32'hFFFFFFFC; end
        end
      end else if ($urandom_range(0, 19) == 0) c_v = 1;
      else if ($urandom_range(0, 59) == 0) begin f_v = 1; n_v = $urandom & 32'hFFFFFFFC; end
      cyc();
    end

    // Free-running tail must keep delivering
    h_v = 0; c_v = 0; w_v = 0; f_v = 0;
    n0 = n_xfer;
    repeat (20) cyc();
    chkb("progress", n_xfer > n0 + 5, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- First pipeline stage; produces the pc/instruction pair consumed by decode.
- Holds the program counter and issues in-order instruction reads to instruction memory.
- Buffers returned words in a small prefetch queue.
- Honours decode's pc-changing stall and the write stage's redirect (has_flushed/next_pc).

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, 2..16.
- RESET_PC, 32'h00000000, pc after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clock  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- is_pc_changing  in  1  from decode: a control-flow instruction is in flight; stop issuing sequential fetches
- has_flushed  in  1  from write stage: redirect this cycle
- next_pc  in  32  redirect target, valid with has_flushed
- hold  in  1  decode back-pressure
- is_valid  out  1  pc/instruction valid to decode
- pc  out  32  address of presented instruction
- instruction  out  32  presented instruction word
- mem_read  out  1  instruction read request
- mem_address  out  32  request address
- mem_wait  in  1  memory cannot accept request this cycle
- mem_data_valid  in  1  read data returning, in request order, latency >= 1 cycle
- mem_data  in  32  returned word

Behaviour:
- Reset (async, reset_n=0):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; state RUN.
  - Outputs: is_valid=0, pc=0, instruction=Nop (32'h80000000), mem_read=0, mem_address=RESET_PC.
- Request accept: mem_read && !mem_wait.
  - On accept: fetch_pc += PC_STEP (mod 2^32, wraps); outstanding++.
  - mem_read and mem_address are stable while mem_wait=1.
- Credit rule: mem_read may assert only when count + outstanding < DEPTH. A response therefore never finds the queue full.
- Response: mem_data_valid writes {address, data} into the queue.
  - Address comes from an internal in-order address FIFO of depth DEPTH.
  - outstanding-- on each response.
- Handshake to decode:
  - Transfer when is_valid && !hold.
  - While hold=1: is_valid, pc and instruction are held stable.
  - is_valid = queue non-empty && state != DRAIN.
  - When not valid, instruction=Nop.
- States:
  - RUN: issues requests per the credit rule.
    - is_pc_changing=1 -> STALL; an unaccepted request is withdrawn.
  - STALL: no new requests; already-queued words remain deliverable.
    - is_pc_changing=0 without has_flushed -> RUN; sequential fetch continues from fetch_pc.
  - DRAIN: queue cleared; remaining in-flight responses are discarded as they arrive.
    - outstanding reaches 0 -> RUN, requesting from the redirect pc.
- Redirect (has_flushed=1, any state; highest priority):
  - Same cycle: queue cleared; is_valid=0 the next cycle; fetch_pc=next_pc.
  - outstanding>0 -> DRAIN, otherwise RUN.
  - Any transfer attempted that cycle is void.
- Simultaneous events:
  - Response and redirect in the same cycle: response discarded and counted off.
  - Accept and redirect in the same cycle: that request counts as outstanding and is drained.
  - Push and pop in the same cycle: count unchanged; a push into an empty queue is visible the next cycle.
- Widths: count/outstanding are $clog2(DEPTH)+1 bits; both saturate by construction (credit rule), never wrap.
- Reset mid-operation: all state returns to reset values immediately. Responses arriving after reset deassertion for pre-reset requests are the memory's responsibility (memory resets too).

Optional Feature:
- FETCH_BYPASS_EN defined:
  - Queue empty, decode not holding, state RUN or STALL, no has_flushed: the arriving mem_data is presented combinationally on instruction/pc with is_valid=1 the same cycle.
  - If accepted, it is not enqueued; if held, it is enqueued normally.
  - Minimum fetch-to-decode latency 0 cycles after response.
- Undefined: every response goes through the queue; minimum latency is 1 cycle after mem_data_valid.

Test Plan:
- Reset release, memory latency 1, no stalls -> addresses 0,4,8,12 requested back-to-back; decode receives pc 0,4,8,12 with matching words; steady throughput 1/cycle after fill.
- hold=1 for 5 cycles with DEPTH=4 -> at most 4 words queued+outstanding; mem_read drops; pc/instruction stable; release drains in order with no loss or duplication.
- is_pc_changing at pc=8, then has_flushed with next_pc=32'h100 while 2 reads outstanding -> DRAIN discards 2 responses; next delivered pc=32'h100; no word from 12/16 reaches decode.
- mem_wait=1 for 3 cycles on address 4 -> mem_address stays 4; fetch_pc advances only on accept.
- fetch_pc=32'hFFFFFFFC sequential -> next request address 0.
- reset_n pulsed low mid-stream with queue full -> same cycle is_valid=0, instruction=32'h80000000; after release, fetch restarts at RESET_PC.
